// File: rtl/parity_pkg.sv
// Shared types and helpers for the multi-channel serial parity checker.
package parity_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

  // Bit counter must hold 0..frame_bits inclusive.
  function automatic int cnt_w(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/parity_chan.sv
// One serial parity channel: data/parity FSM, running XOR, sticky flag and
// saturating failed-frame counter.
module parity_chan
  import parity_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 odd_mode,
  input  logic                 clear,
  input  logic                 x,
  input  logic                 x_valid,
  output logic                 y,
  output logic                 frame_done,
  output logic                 par_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CW = cnt_w(FRAME_BITS);

  state_t               state, state_n;
  logic                 acc, acc_n;
  logic [CW-1:0]        bit_cnt, bit_cnt_n;
  logic                 fd_n, pe_n, sticky_n, mis;
  logic [ERR_CNT_W-1:0] cnt_n;

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    bit_cnt_n = bit_cnt;
    fd_n      = 1'b0;
    pe_n      = 1'b0;
    sticky_n  = err_sticky;
    cnt_n     = err_cnt;
    mis       = 1'b0;
    if (clear) begin
      state_n   = S_DATA;
      acc_n     = 1'b0;
      bit_cnt_n = '0;
      sticky_n  = 1'b0;
      cnt_n     = '0;
    end else if (x_valid) begin
      case (state)
        S_DATA: begin
          acc_n     = acc ^ x;
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == CW'(FRAME_BITS - 1)) state_n = S_PAR;
        end
        S_PAR: begin
          // Parity bit must equal acc ^ odd_mode.
          mis       = x ^ acc ^ odd_mode;
          state_n   = S_DATA;
          acc_n     = 1'b0;
          bit_cnt_n = '0;
          fd_n      = 1'b1;
          pe_n      = mis;
          if (mis) begin
            sticky_n = 1'b1;
            if (!(&err_cnt)) cnt_n = err_cnt + ERR_CNT_W'(1);
          end
        end
        default: state_n = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DATA;
      acc        <= 1'b0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      par_err    <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      bit_cnt    <= bit_cnt_n;
      frame_done <= fd_n;
      par_err    <= pe_n;
      err_sticky <= sticky_n;
      err_cnt    <= cnt_n;
    end
  end

  assign y = acc;

endmodule

// File: rtl/serial_parity_checker.sv
// Multi-channel serial parity checker: CHANNELS independent parity_chan lanes
// sharing odd_mode/clear/reset, with counters packed channel-major.
module serial_parity_checker #(
  parameter int CHANNELS   = 4,
  parameter int FRAME_BITS = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          odd_mode,
  input  logic                          clear,
  input  logic [CHANNELS-1:0]           x,
  input  logic [CHANNELS-1:0]           x_valid,
  output logic [CHANNELS-1:0]           y,
  output logic [CHANNELS-1:0]           frame_done,
  output logic [CHANNELS-1:0]           par_err,
  output logic [CHANNELS-1:0]           err_sticky,
  output logic [CHANNELS*ERR_CNT_W-1:0] err_cnt
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    parity_chan #(
      .FRAME_BITS (FRAME_BITS),
      .ERR_CNT_W  (ERR_CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .odd_mode   (odd_mode),
      .clear      (clear),
      .x          (x[i]),
      .x_valid    (x_valid[i]),
      .y          (y[i]),
      .frame_done (frame_done[i]),
      .par_err    (par_err[i]),
      .err_sticky (err_sticky[i]),
      .err_cnt    (err_cnt[i*ERR_CNT_W +: ERR_CNT_W])
    );
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker (4 channels, 8-bit frames, 2-bit counters).
module tb_serial_parity_checker;

  localparam int CH = 4;
  localparam int FB = 8;
  localparam int EW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            odd_mode = 1'b0;
  logic            clear = 1'b0;
  logic [CH-1:0]   x = '0;
  logic [CH-1:0]   x_valid = '0;
  logic [CH-1:0]   y, frame_done, par_err, err_sticky;
  logic [CH*EW-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  serial_parity_checker #(.CHANNELS(CH), .FRAME_BITS(FB), .ERR_CNT_W(EW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .odd_mode   (odd_mode),
    .clear      (clear),
    .x          (x),
    .x_valid    (x_valid),
    .y          (y),
    .frame_done (frame_done),
    .par_err    (par_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given valid/data, then idle inputs; returns 1 after the edge.
  task automatic step(input logic [CH-1:0] v, input logic [CH-1:0] d);
    x_valid = v;
    x       = d;
    @(posedge clk);
    #1;
    x_valid = '0;
    x       = '0;
  endtask

  initial begin
    logic [0:7]  fr;
    logic [0:7]  ye;
    logic [0:7]  f4;
    logic [0:19] vm1;
    logic [3:0]  efd, epe;
    logic [1:0]  ec;
    logic        cb;

    fr  = 8'b01110110;
    ye  = 8'b01011011;
    f4  = 8'b11000001;
    vm1 = 20'b1011_0010_1110_1001_1011;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_y", y, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_pe", par_err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_cnt", err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Even-mode pass on channel 0
    for (int i = 0; i < 8; i++) begin
      step(4'b0001, {3'b000, fr[i]});
      chk("t1_y", y[0], ye[i]);
      chk("t1_nofd", frame_done, 0);
    end
    step(4'b0001, 4'b0001);
    chk("t1_fd", frame_done, 4'b0001);
    chk("t1_pe", par_err, 0);
    chk("t1_y0", y, 0);
    chk("t1_cnt", err_cnt, 0);
    step(4'b0000, 4'b0000);
    chk("t1_fd_pulse", frame_done, 0);

    // Even-mode fail, then odd-mode pass
    for (int i = 0; i < 8; i++) step(4'b0001, {3'b000, fr[i]});
    step(4'b0001, 4'b0000);
    chk("t2_fd", frame_done, 4'b0001);
    chk("t2_pe", par_err, 4'b0001);
    chk("t2_sticky", err_sticky, 4'b0001);
    chk("t2_cnt", err_cnt, 8'h01);
    odd_mode = 1'b1;
    for (int i = 0; i < 8; i++) step(4'b0001, {3'b000, fr[i]});
    step(4'b0001, 4'b0000);
    chk("t2o_fd", frame_done, 4'b0001);
    chk("t2o_pe", par_err, 0);
    chk("t2o_sticky", err_sticky, 4'b0001);
    chk("t2o_cnt", err_cnt, 8'h01);
    odd_mode = 1'b0;

    // Gaps on channel 1, continuous streams elsewhere
    for (int c = 0; c < 20; c++) begin
      cb = c[0];
      step({1'b1, 1'b1, vm1[c], 1'b1}, {cb, 1'b1, 1'b1, 1'b0});
      efd = 4'b0000;
      epe = 4'b0000;
      if (c == 8)  begin efd = 4'b1101; epe = 4'b0100; end
      if (c == 15) begin efd = 4'b0010; epe = 4'b0010; end
      if (c == 17) begin efd = 4'b1101; epe = 4'b1100; end
      chk("t3_fd", frame_done, efd);
      chk("t3_pe", par_err, epe);
    end
    chk("t3_cnt", err_cnt, 8'b01_10_01_01);
    chk("t3_sticky", err_sticky, 4'b1111);

    // Clear mid-frame on channel 0 (4 bits in), with a bit offered
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0000);
    clear = 1'b1;
    step(4'b1111, 4'b1111);
    clear = 1'b0;
    chk("t4_y", y, 0);
    chk("t4_sticky", err_sticky, 0);
    chk("t4_cnt", err_cnt, 0);
    chk("t4_fd", frame_done, 0);
    chk("t4_pe", par_err, 0);
    for (int i = 0; i < 8; i++) step(4'b0001, {3'b000, f4[i]});
    chk("t4_nofd8", frame_done, 0);
    chk("t4_y8", y[0], 1);
    step(4'b0001, 4'b0001);
    chk("t4_fd9", frame_done, 4'b0001);
    chk("t4_pe9", par_err, 0);

    // Saturation on channel 1
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) step(4'b0010, 4'b0000);
      step(4'b0010, 4'b0010);
      ec = (k >= 2) ? 2'd3 : 2'(k + 1);
      chk("t5_pe", par_err, 4'b0010);
      chk("t5_cnt", err_cnt[3:2], ec);
    end

    // Async reset while channel 0 waits for its parity bit
    for (int i = 0; i < 8; i++) step(4'b0001, {3'b000, (i != 7)});
    chk("t6_pre_y", y[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_y", y, 0);
    chk("t6_sticky", err_sticky, 0);
    chk("t6_cnt", err_cnt, 0);
    chk("t6_fd", frame_done, 0);
    chk("t6_pe", par_err, 0);
    #2 rst_n = 1'b1;
    step(4'b0001, 4'b0001);
    chk("t6_first_fd", frame_done, 0);
    chk("t6_first_y", y[0], 1);
    for (int i = 0; i < 7; i++) step(4'b0001, 4'b0000);
    chk("t6_nofd", frame_done, 0);
    step(4'b0001, 4'b0001);
    chk("t6_fd", frame_done, 4'b0001);
    chk("t6_pe_end", par_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Multi-channel, parametrised serial parity checker. It is the successor to the single-bit `parity` running-parity FSM. Each channel accepts one serial bit per valid cycle, groups bits into frames of `FRAME_BITS` data bits plus one trailing parity bit, and checks the parity bit against a selectable even/odd mode. It reports a per-frame result, a sticky error flag and a saturating error count. It sits between the serial line samplers and the link status/CSR logic.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent serial channels (≥1).
- `FRAME_BITS`, 8: data bits per frame, excluding the parity bit (≥1).
- `ERR_CNT_W`, 8: width of each per-channel error counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `odd_mode`  in  1: 0 selects even parity and 1 selects odd parity. Shared by all channels.
- `clear`  in  1: synchronous clear of all channel state, counters and sticky flags.
- `x`  in  CHANNELS: serial data bit, one per channel.
- `x_valid`  in  CHANNELS: the channel's `x` is accepted this cycle.
- `y`  out  CHANNELS: registered running XOR of the data bits accepted so far in the current frame.
- `frame_done`  out  CHANNELS: one-cycle pulse after a parity bit is accepted.
- `par_err`  out  CHANNELS: one-cycle pulse, coincident with `frame_done`, when the parity check fails.
- `err_sticky`  out  CHANNELS: set by any `par_err`; held until `clear` or reset.
- `err_cnt`  out  CHANNELS*ERR_CNT_W: per-channel failed-frame count. Channel i occupies bits [i*ERR_CNT_W +: ERR_CNT_W]. The count saturates at its maximum value.

## Operation
- Each channel runs an independent two-state FSM: `S_DATA` → `S_PAR` → `S_DATA`.
- **S_DATA:**
  - Each accepted bit updates `acc <= acc ^ x` and increments `bit_cnt`.
  - The bit that makes `bit_cnt` reach `FRAME_BITS` moves the FSM to `S_PAR`.
  - `bit_cnt` is `$clog2(FRAME_BITS+1)` bits wide.
- **S_PAR:**
  - The next accepted bit is the parity bit.
  - The expected parity bit is `acc ^ odd_mode`, so the XOR over data plus parity is 0 in even mode and 1 in odd mode.
  - `odd_mode` is sampled only in this cycle.
  - On acceptance: `acc`←0, `bit_cnt`←0, state←`S_DATA`, and `frame_done` pulses.
  - On mismatch, `par_err` also pulses, `err_sticky` is set and `err_cnt` increments unless it is at its maximum.
- When `x_valid` is 0, nothing in that channel changes. Gaps of any length between bits are legal.
- Channels share no state except `odd_mode`, `clear` and reset.
- **clear:**
  - `clear` has priority over `x_valid` in the same cycle; the bit offered that cycle is discarded.
  - It returns every channel to `S_DATA` with `acc`, `bit_cnt`, `err_sticky` and `err_cnt` at 0.
  - No `frame_done` or `par_err` pulse is produced in that cycle.
- **Reset:** asserting `rst_n` low at any point, including mid-frame, immediately forces all of the following to 0:
  - every output;
  - state (`S_DATA`);
  - `acc` and `bit_cnt`.

## Timing
- **Reset values:** `y`=0, `frame_done`=0, `par_err`=0, `err_sticky`=0, `err_cnt`=0.
- **Latency:** one cycle. A bit accepted at edge N is reflected in `y` after edge N.
- `frame_done` and `par_err` are high for exactly the cycle after edge N, where N is the edge that accepts the parity bit.
- A new frame's first data bit may be accepted in that same cycle. The `frame_done` pulse and the new `y` coexist in that cycle.
- During the `frame_done` cycle, `y` shows 0 until a new data bit is accepted.
- `err_cnt` and `err_sticky` update on the same edge that raises `par_err`.
- Back-to-back frames with `x_valid` held high give one `frame_done` every `FRAME_BITS+1` cycles.

## Structure
- Package `parity_pkg` holds:
  - the `state_t` enum (`S_DATA`, `S_PAR`);
  - a helper function for the counter width.
- Sub-module `parity_chan` implements one channel: FSM, `acc`, `bit_cnt`, sticky flag and saturating counter.
- The top level instantiates `CHANNELS` copies in a generate loop and packs the outputs.

## Test plan
- **Even-mode pass.** Stimulus: `odd_mode`=0; channel 0 receives data bits 0,1,1,1,0,1,1,0 then parity bit 1. Response: `y` sequence 0,1,0,1,1,0,1,1; `frame_done`[0] pulses once; `par_err`[0]=0; `err_cnt`[0]=0.
- **Even-mode fail and odd-mode pass.** Stimulus: repeat the same frame with parity bit 0, then switch to `odd_mode`=1 and send parity bit 0. Response: the first frame raises `par_err` and `err_sticky`, with `err_cnt`=1. The odd-mode frame passes, and `err_sticky` stays 1.
- **Gaps and independence.** Stimulus: channel 1 toggles `x_valid` randomly while channels 0, 2 and 3 stream continuously. Response: each channel's `frame_done` lands after exactly 9 accepted bits, and results are independent of the other channels.
- **Saturation.** Stimulus: `ERR_CNT_W`=2; send 5 bad frames. Response: `err_cnt` reads 1, 2, 3, 3, 3, and `par_err` still pulses every time.
- **Clear with bit.** Stimulus: assert `clear` mid-frame, after 4 bits, in the same cycle as `x_valid`. Response: that bit is discarded; `y`=0, `err_sticky`=0 and `err_cnt`=0 next cycle; the next 8 bits plus parity form a complete frame.
- **Async reset.** Stimulus: drop `rst_n` between clock edges while in `S_PAR`. Response: all outputs go to 0 immediately, without waiting for a clock edge. After release, the first bit is treated as data bit 1.
